// File: rtl/wb_pkg.sv
// Shared writeback-stage definitions: load funct3 encodings and default datapath types.
package wb_pkg;
  localparam int WB_XLEN  = 32;
  localparam int WB_NREGS = 32;

  localparam logic [2:0] LT_LB  = 3'b000;
  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LW  = 3'b010;
  localparam logic [2:0] LT_LD  = 3'b011;
  localparam logic [2:0] LT_LBU = 3'b100;
  localparam logic [2:0] LT_LHU = 3'b101;
  localparam logic [2:0] LT_LWU = 3'b110;

  typedef logic [$clog2(WB_NREGS)-1:0] reg_tag_t;
  typedef logic [WB_XLEN-1:0]          xword_t;
endpackage

// File: rtl/load_align.sv
// Combinational load lane select and sign/zero extension.
module load_align
  import wb_pkg::*;
#(
  parameter int XLEN = WB_XLEN,
  localparam int OW  = $clog2(XLEN/8)
) (
  input  logic [XLEN-1:0] word,
  input  logic [OW-1:0]   offset,
  input  logic [2:0]      load_type,
  output logic [XLEN-1:0] data
);
  // Misaligned halves/words round the offset down instead of trapping.
  logic [OW-1:0] off_h, off_w;
  logic [7:0]    b;
  logic [15:0]   h;
  logic [31:0]   w;

  assign off_h = offset & ~OW'(1);
  assign off_w = offset & ~OW'(3);
  assign b = word[{offset, 3'b000} +: 8];
  assign h = word[{off_h,  3'b000} +: 16];
  assign w = word[{off_w,  3'b000} +: 32];

  always_comb begin
    data = word;
    case (load_type)
      LT_LB:   data = XLEN'($signed(b));
      LT_LBU:  data = XLEN'(b);
      LT_LH:   data = XLEN'($signed(h));
      LT_LHU:  data = XLEN'(h);
      LT_LW:   data = XLEN'($signed(w));
      LT_LWU:  data = XLEN'(w);
      LT_LD:   data = word;
      default: data = word;
    endcase
  end
endmodule

// File: rtl/stage5_writeback.sv
// Writeback stage: result select, register file with write-first bypass, instret counter.
module stage5_writeback
  import wb_pkg::*;
#(
  parameter int XLEN  = WB_XLEN,
  parameter int NREGS = WB_NREGS,
  parameter int NREAD = 2,
  localparam int AW   = $clog2(NREGS),
  localparam int OW   = $clog2(XLEN/8)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  stall,
  input  logic                  valid,
  input  logic                  write_rd,
  input  logic                  is_load,
  input  logic                  is_link,
  input  logic [2:0]            load_type,
  input  logic [AW-1:0]         rd,
  input  logic [XLEN-1:0]       alu_output,
  input  logic [XLEN-1:0]       link_addr,
  input  logic [XLEN-1:0]       mem_rdata,
  input  logic [NREAD*AW-1:0]   rs_addr,
  output logic [NREAD*XLEN-1:0] rs_data,
  output logic [XLEN-1:0]       rd_value,
  output logic                  commit,
  output logic [63:0]           instret
);
  logic [XLEN-1:0] regs [NREGS];
  logic [XLEN-1:0] load_data;
  logic [63:0]     instret_q;
  logic            wr_en;

  load_align #(.XLEN(XLEN)) u_align (
    .word      (mem_rdata),
    .offset    (alu_output[OW-1:0]),
    .load_type (load_type),
    .data      (load_data)
  );

  assign commit   = valid & ~stall;
  assign wr_en    = commit & write_rd & (rd != '0);
  assign rd_value = is_load ? load_data : (is_link ? link_addr : alu_output);
  assign instret  = instret_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      instret_q <= '0;
    end else begin
      if (wr_en)  regs[rd]  <= rd_value;
      if (commit) instret_q <= instret_q + 64'd1;
    end
  end

  // x0 is never written, but the zero check keeps reads independent of array contents.
  for (genvar p = 0; p < NREAD; p++) begin : g_rd
    logic [AW-1:0] a;
    assign a = rs_addr[p*AW +: AW];
    assign rs_data[p*XLEN +: XLEN] = (a == '0)                  ? '0       :
                                     (wr_en && rd == a)         ? rd_value :
                                                                  regs[a];
  end
endmodule
